// File: rtl/learning_score_pkg.sv
// Shared codes for the learning-mode scorer: judgement, grade, FSM state.
// Also holds a saturating 8-bit increment used by the hit/miss/combo counters.
package learning_score_pkg;

    typedef enum logic [1:0] {
        JUDGE_NONE    = 2'd0,
        JUDGE_PERFECT = 2'd1,
        JUDGE_GOOD    = 2'd2,
        JUDGE_MISS    = 2'd3
    } judge_e;

    typedef enum logic [2:0] {
        GRADE_NONE = 3'd0,
        GRADE_A    = 3'd1,
        GRADE_B    = 3'd2,
        GRADE_C    = 3'd3,
        GRADE_D    = 3'd4
    } grade_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_JUDGED,
        ST_FINISHED
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/learning_grade_calc.sv
// Combinational letter grade from final hit/miss counts.
// Ports: hits_i, misses_i (8b counts) -> grade_o (grade_e code).
module learning_grade_calc
    import learning_score_pkg::*;
(
    input  logic [7:0] hits_i,
    input  logic [7:0] misses_i,
    output grade_e     grade_o
);

    logic [8:0]  n;
    logic [13:0] h10, n9, h4, n3, h2, n1;

    // 14-bit products: 510 * 9 does not fit in 12 bits.
    assign n   = {1'b0, hits_i} + {1'b0, misses_i};
    assign h10 = 14'(hits_i) * 14'd10;
    assign n9  = 14'(n) * 14'd9;
    assign h4  = 14'(hits_i) * 14'd4;
    assign n3  = 14'(n) * 14'd3;
    assign h2  = 14'(hits_i) * 14'd2;
    assign n1  = 14'(n);

    // Thresholds overlap (an A also clears B), so order matters here.
    always_comb begin
        grade_o = GRADE_D;
        if (n == 9'd0)       grade_o = GRADE_D;
        else if (h10 >= n9)  grade_o = GRADE_A;
        else if (h4 >= n3)   grade_o = GRADE_B;
        else if (h2 >= n1)   grade_o = GRADE_C;
        else                 grade_o = GRADE_D;
    end

endmodule

// File: rtl/learning_scorer.sv
// Learning-mode scorer: judges key presses against the expected note,
// keeps score/hit/miss/combo stats and grades the song at song_done.
// Ports: clk, reset (async, active-high); key_in, expected, note_strobe,
// song_start, song_done in; score, hit_count, miss_count, combo,
// max_combo, judge, judge_pulse, grade, grade_valid out.
module learning_scorer
    import learning_score_pkg::*;
#(
    parameter int WINDOW_CYCLES  = 50_000_000,
    parameter int PERFECT_CYCLES = 12_500_000,
    parameter int PTS_PERFECT    = 10,
    parameter int PTS_GOOD       = 5,
    parameter int SCORE_MAX      = 999
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] key_in,
    input  logic [6:0] expected,
    input  logic       note_strobe,
    input  logic       song_start,
    input  logic       song_done,
    output logic [9:0] score,
    output logic [7:0] hit_count,
    output logic [7:0] miss_count,
    output logic [7:0] combo,
    output logic [7:0] max_combo,
    output logic [1:0] judge,
    output logic       judge_pulse,
    output logic [2:0] grade,
    output logic       grade_valid
);

    localparam int TW = $clog2(WINDOW_CYCLES + 1);

    state_e      state_q, state_d;
    logic [6:0]  exp_q, exp_d;
    logic [6:0]  key_prev_q;
    logic [TW-1:0] timer_q, timer_d;
    logic [9:0]  score_q, score_d;
    logic [7:0]  hit_q, hit_d;
    logic [7:0]  miss_q, miss_d;
    logic [7:0]  combo_q, combo_d;
    logic [7:0]  maxc_q, maxc_d;
    judge_e      judge_q, judge_d;
    logic        pulse_q, pulse_d;
    grade_e      grade_q, grade_d;
    logic        gvalid_q, gvalid_d;

    logic [6:0]  rise;
    logic        hit_ev, miss_ev, perfect;
    logic        take_note, done, clear;
    logic [10:0] sum;
    grade_e      calc_grade;

    assign rise = key_in & ~key_prev_q;

    // Grade sees the post-update miss count so that a note still armed
    // at song_done is counted before grading.
    learning_grade_calc u_grade (
        .hits_i   (hit_q),
        .misses_i (miss_d),
        .grade_o  (calc_grade)
    );

    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        timer_d   = timer_q;
        grade_d   = grade_q;
        gvalid_d  = gvalid_q;
        hit_ev    = 1'b0;
        miss_ev   = 1'b0;
        perfect   = 1'b0;
        take_note = 1'b0;
        done      = 1'b0;
        clear     = 1'b0;
        if (song_start) begin
            clear    = 1'b1;
            state_d  = ST_IDLE;
            exp_d    = '0;
            timer_d  = '0;
            grade_d  = GRADE_NONE;
            gvalid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_JUDGED: begin
                    if (song_done)        done = 1'b1;
                    else if (note_strobe) take_note = 1'b1;
                end
                ST_ARMED: begin
                    if (song_done) begin
                        miss_ev = 1'b1;
                        done    = 1'b1;
                    end else if (note_strobe) begin
                        miss_ev   = 1'b1;
                        take_note = 1'b1;
                    end else if (rise != 7'd0) begin
                        if (rise == exp_q) begin
                            hit_ev  = 1'b1;
                            perfect = timer_q < TW'(PERFECT_CYCLES);
                        end else begin
                            miss_ev = 1'b1;
                        end
                        state_d = ST_JUDGED;
                    end else if (timer_q == TW'(WINDOW_CYCLES - 1)) begin
                        miss_ev = 1'b1;
                        state_d = ST_JUDGED;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_FINISHED: state_d = ST_FINISHED;
                default:     state_d = ST_IDLE;
            endcase
            if (take_note) begin
                if (expected != 7'd0) begin
                    exp_d   = expected;
                    timer_d = '0;
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_JUDGED;
                end
            end
            if (done) begin
                state_d  = ST_FINISHED;
                grade_d  = calc_grade;
                gvalid_d = 1'b1;
            end
        end
    end

    always_comb begin
        score_d = score_q;
        hit_d   = hit_q;
        miss_d  = miss_q;
        combo_d = combo_q;
        maxc_d  = maxc_q;
        judge_d = judge_q;
        pulse_d = 1'b0;
        sum = {1'b0, score_q}
            + (perfect ? 11'(PTS_PERFECT) : 11'(PTS_GOOD));
        if (clear) begin
            score_d = '0;
            hit_d   = '0;
            miss_d  = '0;
            combo_d = '0;
            maxc_d  = '0;
            judge_d = JUDGE_NONE;
        end else if (hit_ev) begin
            score_d = (sum > 11'(SCORE_MAX)) ? 10'(SCORE_MAX) : sum[9:0];
            hit_d   = sat_inc8(hit_q);
            combo_d = sat_inc8(combo_q);
            if (combo_d > maxc_q) maxc_d = combo_d;
            judge_d = perfect ? JUDGE_PERFECT : JUDGE_GOOD;
            pulse_d = 1'b1;
        end else if (miss_ev) begin
            miss_d  = sat_inc8(miss_q);
            combo_d = '0;
            judge_d = JUDGE_MISS;
            pulse_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            exp_q      <= '0;
            key_prev_q <= '0;
            timer_q    <= '0;
            score_q    <= '0;
            hit_q      <= '0;
            miss_q     <= '0;
            combo_q    <= '0;
            maxc_q     <= '0;
            judge_q    <= JUDGE_NONE;
            pulse_q    <= 1'b0;
            grade_q    <= GRADE_NONE;
            gvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            key_prev_q <= key_in;
            timer_q    <= timer_d;
            score_q    <= score_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            combo_q    <= combo_d;
            maxc_q     <= maxc_d;
            judge_q    <= judge_d;
            pulse_q    <= pulse_d;
            grade_q    <= grade_d;
            gvalid_q   <= gvalid_d;
        end
    end

    assign score       = score_q;
    assign hit_count   = hit_q;
    assign miss_count  = miss_q;
    assign combo       = combo_q;
    assign max_combo   = maxc_q;
    assign judge       = judge_q;
    assign judge_pulse = pulse_q;
    assign grade       = grade_q;
    assign grade_valid = gvalid_q;

endmodule

// File: tb/tb_learning_scorer.sv
// Directed bench for learning_scorer with a judgement scoreboard.
// Expected judge codes are queued at stimulus time and popped on judge_pulse.
module tb_learning_scorer;

    localparam int WIN  = 20;
    localparam int PERF = 5;
    localparam int PP   = 10;
    localparam int PG   = 5;
    localparam int SMAX = 999;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] key_in = '0;
    logic [6:0] expected = '0;
    logic       note_strobe = 1'b0;
    logic       song_start = 1'b0;
    logic       song_done = 1'b0;
    logic [9:0] score;
    logic [7:0] hit_count, miss_count, combo, max_combo;
    logic [1:0] judge;
    logic       judge_pulse;
    logic [2:0] grade;
    logic       grade_valid;

    learning_scorer #(
        .WINDOW_CYCLES  (WIN),
        .PERFECT_CYCLES (PERF),
        .PTS_PERFECT    (PP),
        .PTS_GOOD       (PG),
        .SCORE_MAX      (SMAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_in      (key_in),
        .expected    (expected),
        .note_strobe (note_strobe),
        .song_start  (song_start),
        .song_done   (song_done),
        .score       (score),
        .hit_count   (hit_count),
        .miss_count  (miss_count),
        .combo       (combo),
        .max_combo   (max_combo),
        .judge       (judge),
        .judge_pulse (judge_pulse),
        .grade       (grade),
        .grade_valid (grade_valid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int sb[$];
    int mon_e;

    int m_score, m_hits, m_miss, m_combo, m_max, m_judge, m_grade, m_gv;

    task automatic chk(string tag, int obs, int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (judge_pulse === 1'b1) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_pulse: got judge %0d, expected none",
                       judge);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("judge_sb", int'(judge), mon_e);
            end
        end
    end

    task automatic m_clear();
        m_score = 0; m_hits = 0; m_miss = 0; m_combo = 0;
        m_max = 0; m_judge = 0; m_grade = 0; m_gv = 0;
    endtask

    task automatic m_hit(bit perf);
        m_score = m_score + (perf ? PP : PG);
        if (m_score > SMAX) m_score = SMAX;
        if (m_hits < 255) m_hits++;
        if (m_combo < 255) m_combo++;
        if (m_combo > m_max) m_max = m_combo;
        m_judge = perf ? 1 : 2;
        sb.push_back(m_judge);
    endtask

    task automatic m_miss_ev();
        if (m_miss < 255) m_miss++;
        m_combo = 0;
        m_judge = 3;
        sb.push_back(3);
    endtask

    function automatic int ref_grade(int h, int m);
        int n;
        n = h + m;
        if (n == 0) return 4;
        if (h * 10 >= n * 9) return 1;
        if (h * 4 >= n * 3) return 2;
        if (h * 2 >= n) return 3;
        return 4;
    endfunction

    task automatic chk_stats(string tag);
        chk({tag, "_score"}, int'(score), m_score);
        chk({tag, "_hits"}, int'(hit_count), m_hits);
        chk({tag, "_miss"}, int'(miss_count), m_miss);
        chk({tag, "_combo"}, int'(combo), m_combo);
        chk({tag, "_maxc"}, int'(max_combo), m_max);
        chk({tag, "_judge"}, int'(judge), m_judge);
        chk({tag, "_grade"}, int'(grade), m_grade);
        chk({tag, "_gv"}, int'(grade_valid), m_gv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(logic [6:0] e);
        expected = e;
        note_strobe = 1'b1;
        tick();
        note_strobe = 1'b0;
        expected = '0;
    endtask

    task automatic press(logic [6:0] k, bit perf);
        key_in = k;
        m_hit(perf);
        tick();
        key_in = '0;
        tick();
    endtask

    task automatic hit_note(logic [6:0] k, int wait_n);
        strobe(k);
        repeat (wait_n) tick();
        press(k, wait_n < PERF);
    endtask

    task automatic wrong_note();
        strobe(7'b0000001);
        key_in = 7'b0000010;
        m_miss_ev();
        tick();
        key_in = '0;
        tick();
    endtask

    task automatic start_song();
        song_start = 1'b1;
        tick();
        song_start = 1'b0;
        m_clear();
    endtask

    task automatic grade_case(string tag, int h, int m);
        start_song();
        repeat (h) hit_note(7'b0000001, 1);
        if (m > 0) begin
            repeat (m - 1) wrong_note();
            strobe(7'b0000001);
            tick();
            m_miss_ev();
        end
        song_done = 1'b1;
        chk({tag, "_gv_before"}, int'(grade_valid), 0);
        tick();
        song_done = 1'b0;
        m_grade = ref_grade(h, m);
        m_gv = 1;
        chk_stats(tag);
        tick();
    endtask

    initial begin
        m_clear();
        repeat (3) tick();
        chk_stats("reset");
        chk("reset_pulse", int'(judge_pulse), 0);
        reset = 1'b0;
        tick();

        hit_note(7'b0000100, 2);
        chk_stats("perfect");

        hit_note(7'b0000100, 7);
        chk_stats("good");

        wrong_note();
        chk_stats("wrong");

        strobe(7'b0001000);
        repeat (WIN - 1) tick();
        chk_stats("tmo_pre");
        m_miss_ev();
        tick();
        chk_stats("tmo");

        strobe(7'b0010000);
        repeat (9) tick();
        m_miss_ev();
        strobe(7'b0100000);
        chk_stats("overlap");
        press(7'b0100000, 1'b1);
        chk_stats("overlap_hit");

        strobe(7'b0000000);
        key_in = 7'h7F;
        tick();
        key_in = '0;
        tick();
        chk_stats("rest");

        key_in = 7'b1000000;
        tick();
        strobe(7'b1000000);
        repeat (WIN - 1) tick();
        chk_stats("held_pre");
        m_miss_ev();
        tick();
        chk_stats("held");
        key_in = '0;
        tick();

        repeat (100) hit_note(7'b0000001, 0);
        chk_stats("sat");

        grade_case("gA", 9, 1);
        grade_case("gB", 3, 1);
        grade_case("gC", 1, 1);
        grade_case("gD", 0, 0);

        strobe(7'b0000001);
        key_in = 7'b0000001;
        tick();
        key_in = '0;
        song_done = 1'b1;
        tick();
        song_done = 1'b0;
        chk_stats("finished");

        start_song();
        hit_note(7'b0000001, 1);
        song_start = 1'b1;
        note_strobe = 1'b1;
        expected = 7'b0000001;
        tick();
        song_start = 1'b0;
        note_strobe = 1'b0;
        expected = '0;
        m_clear();
        chk_stats("start_coinc");
        key_in = 7'b0000001;
        tick();
        key_in = '0;
        tick();
        chk_stats("start_idle");

        hit_note(7'b0000010, 1);
        strobe(7'b0000010);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        m_clear();
        chk_stats("rst_mid");
        chk("rst_mid_pulse", int'(judge_pulse), 0);
        tick();
        reset = 1'b0;
        tick();
        key_in = 7'b0000010;
        tick();
        key_in = '0;
        tick();
        chk_stats("rst_idle");
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
